// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the 5-stage MIPS pipeline sequencer:
//   - bit positions and width of the 10-bit control bundle
//   - primary opcode constants seen by the ID-stage decoder
//   - sequencer FSM state encoding and PC-select encodings
//   - ctl_decode(): reference opcode -> control bundle mapping used by the
//     ID-stage decoder that feeds pipe_hazard_ctrl
// -----------------------------------------------------------------------------
package pipeline_pkg;

  // Control bundle layout, MSB first:
  // {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp[1:0]}
  localparam int CTL_W        = 10;
  localparam int CTL_REGDST   = 9;
  localparam int CTL_ALUSRC   = 8;
  localparam int CTL_MEMTOREG = 7;
  localparam int CTL_REGWRITE = 6;
  localparam int CTL_MEMREAD  = 5;
  localparam int CTL_MEMWRITE = 4;
  localparam int CTL_BRANCH   = 3;
  localparam int CTL_JUMP     = 2;
  localparam int CTL_ALUOP    = 0;  // LSB of the 2-bit ALUOp field
  localparam int CTL_ALUOP_W  = 2;

  // Primary opcodes (instruction bits [31:26])
  localparam logic [5:0] R_FORMAT = 6'd0;
  localparam logic [5:0] J        = 6'd2;
  localparam logic [5:0] BEQ      = 6'd4;
  localparam logic [5:0] LW       = 6'd35;
  localparam logic [5:0] SW       = 6'd43;

  // Next-PC source select
  localparam logic [1:0] PC_SEL_SEQ = 2'b00;  // PC + 4
  localparam logic [1:0] PC_SEL_BR  = 2'b01;  // branch target
  localparam logic [1:0] PC_SEL_JMP = 2'b10;  // jump target

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  // Reference decode; don't-care fields are driven to 0.
  function automatic logic [CTL_W-1:0] ctl_decode(input logic [5:0] opcode);
    logic [CTL_W-1:0] c;
    c = '0;
    case (opcode)
      R_FORMAT: begin
        c[CTL_REGDST]   = 1'b1;
        c[CTL_REGWRITE] = 1'b1;
        c[CTL_ALUOP +: CTL_ALUOP_W] = 2'b10;
      end
      LW: begin
        c[CTL_ALUSRC]   = 1'b1;
        c[CTL_MEMTOREG] = 1'b1;
        c[CTL_REGWRITE] = 1'b1;
        c[CTL_MEMREAD]  = 1'b1;
      end
      SW: begin
        c[CTL_ALUSRC]   = 1'b1;
        c[CTL_MEMWRITE] = 1'b1;
      end
      BEQ: begin
        c[CTL_BRANCH] = 1'b1;
        c[CTL_ALUOP +: CTL_ALUOP_W] = 2'b01;
      end
      J: begin
        c[CTL_JUMP] = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard detector. A hazard exists when the load in EX
// writes a non-zero register that the instruction in ID reads: rs is always
// read, rt only when the ID instruction actually consumes it (store data,
// branch compare, or R-format second operand).
// Ports:
//   id_reg_write, id_alu_src, id_mem_write, id_branch : ID-stage control bits
//   rs_id, rt_id    : ID-stage source register fields
//   ex_mem_read     : MemRead bit of the ID/EX control register
//   rt_ex           : destination (rt) of the instruction in EX
//   load_use        : stall request for one bubble
// -----------------------------------------------------------------------------
module hazard_detect (
  input  logic       id_reg_write,
  input  logic       id_alu_src,
  input  logic       id_mem_write,
  input  logic       id_branch,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       ex_mem_read,
  input  logic [4:0] rt_ex,
  output logic       load_use
);

  logic use_rt;

  always_comb begin
    use_rt   = id_mem_write | id_branch | (id_reg_write & ~id_alu_src);
    load_use = ex_mem_read & (rt_ex != 5'd0) &
               ((rt_ex == rs_id) | (use_rt & (rt_ex == rt_id)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline sequencer for the 5-stage MIPS pipeline. Owns the ID/EX, EX/MEM and
// MEM/WB control-bundle registers, inserts load-use bubbles, flushes IF/ID on
// taken branches and jumps, freezes the pipe while a data-memory access is
// outstanding and counts stalled cycles.
//
// Memory handshake: mem_req is high whenever the bundle in MEM is a load or a
// store; the access completes in any cycle where mem_req and mem_ack are both
// high. Until then the pipe is frozen, bounded by MEM_TIMEOUT wait cycles after
// which the access is treated as acknowledged and mem_err is set (sticky).
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   ctrl_id           : ID-stage control bundle from the decoder
//   rs_id, rt_id      : ID-stage register fields
//   alu_zero_ex       : EX-stage ALU zero flag (branch resolve)
//   mem_ack           : data memory completes the current access
//   ctrl_ex/mem/wb    : pipeline control registers
//   pc_write, ifid_write, ifid_flush, pc_sel : fetch-side controls
//   mem_req, mem_err  : data memory request, sticky timeout flag
//   stall_count       : saturating count of cycles with pc_write low
//   dbg_state         : sequencer FSM state
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,  // must be >= 1
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CTL_W-1:0] ctrl_id,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             alu_zero_ex,
  input  logic             mem_ack,
  output logic [CTL_W-1:0] ctrl_ex,
  output logic [CTL_W-1:0] ctrl_mem,
  output logic [1:0]       ctrl_wb,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic [1:0]       pc_sel,
  output logic             mem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count,
  output state_e           dbg_state
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CTL_W-1:0]   ctrl_ex_q, ctrl_ex_d;
  logic [CTL_W-1:0]   ctrl_mem_q, ctrl_mem_d;
  logic [1:0]         ctrl_wb_q, ctrl_wb_d;
  logic [4:0]         rt_ex_q, rt_ex_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic br_taken;
  logic timeout_hit;
  logic freeze;
  logic mem_req_w;

  hazard_detect u_hazard_detect (
    .id_reg_write (ctrl_id[CTL_REGWRITE]),
    .id_alu_src   (ctrl_id[CTL_ALUSRC]),
    .id_mem_write (ctrl_id[CTL_MEMWRITE]),
    .id_branch    (ctrl_id[CTL_BRANCH]),
    .rs_id        (rs_id),
    .rt_id        (rt_id),
    .ex_mem_read  (ctrl_ex_q[CTL_MEMREAD]),
    .rt_ex        (rt_ex_q),
    .load_use     (load_use)
  );

  // The last allowed wait cycle behaves as an ack so the pipe never deadlocks.
  always_comb begin
    mem_req_w   = ctrl_mem_q[CTL_MEMREAD] | ctrl_mem_q[CTL_MEMWRITE];
    br_taken    = ctrl_ex_q[CTL_BRANCH] & alu_zero_ex;
    timeout_hit = (state_q == MEM_WAIT) && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));
    freeze      = mem_req_w & ~mem_ack & ~timeout_hit;
  end

  // Pipeline register steering and fetch controls, highest priority first:
  // freeze > taken branch > load-use bubble > jump > normal advance.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    pc_sel     = PC_SEL_SEQ;
    ctrl_ex_d  = ctrl_id;
    rt_ex_d    = rt_id;
    ctrl_mem_d = ctrl_ex_q;
    ctrl_wb_d  = {ctrl_mem_q[CTL_REGWRITE], ctrl_mem_q[CTL_MEMTOREG]};

    if (freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ctrl_ex_d  = ctrl_ex_q;
      rt_ex_d    = rt_ex_q;
      ctrl_mem_d = ctrl_mem_q;
      ctrl_wb_d  = '0;  // the access has not completed, nothing retires
    end else if (br_taken) begin
      // Squashes the ID instruction, so any hazard or jump it carried is moot.
      pc_sel     = PC_SEL_BR;
      ifid_flush = 1'b1;
      ctrl_ex_d  = '0;
      rt_ex_d    = '0;
    end else if (load_use) begin
      // The bubble clears MemRead in EX, so the hazard cannot repeat next cycle.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ctrl_ex_d  = '0;
      rt_ex_d    = '0;
    end else if (ctrl_id[CTL_JUMP]) begin
      pc_sel     = PC_SEL_JMP;
      ifid_flush = 1'b1;
    end
  end

  // Memory wait FSM and sticky timeout error.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      RUN: begin
        if (mem_req_w && !mem_ack) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_d = RUN;
        end else if (timeout_hit) begin
          state_d   = RUN;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Counts every cycle the PC is held; flush cycles keep pc_write high.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      ctrl_ex_q   <= '0;
      ctrl_mem_q  <= '0;
      ctrl_wb_q   <= '0;
      rt_ex_q     <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      ctrl_ex_q   <= ctrl_ex_d;
      ctrl_mem_q  <= ctrl_mem_d;
      ctrl_wb_q   <= ctrl_wb_d;
      rt_ex_q     <= rt_ex_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ctrl_ex     = ctrl_ex_q;
  assign ctrl_mem    = ctrl_mem_q;
  assign ctrl_wb     = ctrl_wb_q;
  assign mem_req     = mem_req_w;
  assign mem_err     = mem_err_q;
  assign stall_count = stall_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=4 and a 4-bit stall
// counter so saturation is reachable. Control bundles are hand-encoded:
//   R  = 10'h242  LW = 10'h1E0  SW = 10'h110  BEQ = 10'h009  J = 10'h004
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam logic [9:0] C_R   = 10'h242;
  localparam logic [9:0] C_LW  = 10'h1E0;
  localparam logic [9:0] C_SW  = 10'h110;
  localparam logic [9:0] C_BEQ = 10'h009;
  localparam logic [9:0] C_J   = 10'h004;
  localparam logic [9:0] C_BRL = 10'h029;  // Branch + MemRead, to pair a taken branch with a load-use
  localparam logic [9:0] C_NOP = 10'h000;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [9:0] ctrl_id;
  logic [4:0] rs_id, rt_id;
  logic       alu_zero_ex, mem_ack;
  logic [9:0] ctrl_ex, ctrl_mem;
  logic [1:0] ctrl_wb, pc_sel;
  logic       pc_write, ifid_write, ifid_flush, mem_req, mem_err;
  logic [3:0] stall_count;
  pipeline_pkg::state_e dbg_state;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .ctrl_id     (ctrl_id),
    .rs_id       (rs_id),
    .rt_id       (rt_id),
    .alu_zero_ex (alu_zero_ex),
    .mem_ack     (mem_ack),
    .ctrl_ex     (ctrl_ex),
    .ctrl_mem    (ctrl_mem),
    .ctrl_wb     (ctrl_wb),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .pc_sel      (pc_sel),
    .mem_req     (mem_req),
    .mem_err     (mem_err),
    .stall_count (stall_count),
    .dbg_state   (dbg_state)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] c, input logic [4:0] rs, input logic [4:0] rt);
    ctrl_id = c;
    rs_id   = rs;
    rt_id   = rt;
    #1;
  endtask

  logic [31:0] st_run, st_wait;

  initial begin
    st_run  = 32'(pipeline_pkg::RUN);
    st_wait = 32'(pipeline_pkg::MEM_WAIT);
    reset = 1'b1; ctrl_id = '0; rs_id = '0; rt_id = '0;
    alu_zero_ex = 1'b0; mem_ack = 1'b1;
    tick(); tick();

    // reset state
    check("rst_ctrl_ex", 32'(ctrl_ex), 0);
    check("rst_ctrl_mem", 32'(ctrl_mem), 0);
    check("rst_ctrl_wb", 32'(ctrl_wb), 0);
    check("rst_pc_write", 32'(pc_write), 1);
    check("rst_ifid_write", 32'(ifid_write), 1);
    check("rst_ifid_flush", 32'(ifid_flush), 0);
    check("rst_pc_sel", 32'(pc_sel), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_err", 32'(mem_err), 0);
    check("rst_stall", 32'(stall_count), 0);
    check("rst_state", 32'(dbg_state), st_run);
    reset = 1'b0;

    // load-use on rs: exactly one bubble
    drive(C_LW, 5'd1, 5'd8); tick();
    drive(C_R, 5'd8, 5'd2);
    check("lu_pc_write", 32'(pc_write), 0);
    check("lu_ifid_write", 32'(ifid_write), 0);
    check("lu_pc_sel", 32'(pc_sel), 0);
    tick();
    check("lu_bubble", 32'(ctrl_ex), 0);
    check("lu_stall", 32'(stall_count), 1);
    check("lu_mem", 32'(ctrl_mem), 32'(C_LW));
    check("lu_no_repeat", 32'(pc_write), 1);
    tick();
    check("lu_r_in_ex", 32'(ctrl_ex), 32'(C_R));
    check("lu_wb", 32'(ctrl_wb), 3);
    check("lu_stall2", 32'(stall_count), 1);

    // rt == 0 never hazards; rt unused by a load consumer
    drive(C_LW, 5'd1, 5'd0); tick();
    drive(C_R, 5'd0, 5'd0);
    check("rt0_pc_write", 32'(pc_write), 1);
    tick();
    check("rt0_ex", 32'(ctrl_ex), 32'(C_R));
    drive(C_LW, 5'd1, 5'd9); tick();
    drive(C_LW, 5'd3, 5'd9);
    check("rtunused_pc_write", 32'(pc_write), 1);
    tick();
    check("rtunused_ex", 32'(ctrl_ex), 32'(C_LW));
    check("rtunused_stall", 32'(stall_count), 1);
    // store data uses rt -> hazard
    drive(C_SW, 5'd3, 5'd9);
    check("sw_rt_pc_write", 32'(pc_write), 0);
    tick();
    check("sw_rt_stall", 32'(stall_count), 2);
    tick();
    check("sw_rt_ex", 32'(ctrl_ex), 32'(C_SW));

    // taken branch beats a simultaneous load-use
    drive(C_BRL, 5'd1, 5'd8); tick();
    alu_zero_ex = 1'b1;
    drive(C_R, 5'd8, 5'd2);
    check("br_pc_sel", 32'(pc_sel), 1);
    check("br_flush", 32'(ifid_flush), 1);
    check("br_pc_write", 32'(pc_write), 1);
    check("br_ifid_write", 32'(ifid_write), 1);
    tick();
    alu_zero_ex = 1'b0;
    check("br_ex", 32'(ctrl_ex), 0);
    check("br_stall", 32'(stall_count), 2);
    // branch not taken
    drive(C_BEQ, 5'd1, 5'd2); tick();
    drive(C_NOP, 5'd0, 5'd0);
    check("bnt_pc_sel", 32'(pc_sel), 0);
    check("bnt_flush", 32'(ifid_flush), 0);
    tick();

    // jump: one cycle of redirect
    drive(C_J, 5'd0, 5'd0);
    check("j_pc_sel", 32'(pc_sel), 2);
    check("j_flush", 32'(ifid_flush), 1);
    check("j_pc_write", 32'(pc_write), 1);
    tick();
    check("j_ex", 32'(ctrl_ex), 32'(C_J));
    drive(C_NOP, 5'd0, 5'd0);
    check("j_pc_sel_after", 32'(pc_sel), 0);
    check("j_flush_after", 32'(ifid_flush), 0);
    tick();

    // store waits 3 cycles for ack
    drive(C_R, 5'd1, 5'd2); tick();
    drive(C_SW, 5'd1, 5'd2); tick();
    drive(C_R, 5'd4, 5'd5); tick();
    check("sw_wb_before", 32'(ctrl_wb), 2);
    mem_ack = 1'b0;
    drive(C_NOP, 5'd0, 5'd0);
    check("sw_mem_req", 32'(mem_req), 1);
    check("sw_frz_pc_write", 32'(pc_write), 0);
    check("sw_frz_ifid_write", 32'(ifid_write), 0);
    tick();
    check("sw_frz_wb", 32'(ctrl_wb), 0);
    check("sw_frz_mem", 32'(ctrl_mem), 32'(C_SW));
    check("sw_frz_state", 32'(dbg_state), st_wait);
    check("sw_frz_pc_write2", 32'(pc_write), 0);
    tick();
    check("sw_frz_ex", 32'(ctrl_ex), 32'(C_R));
    check("sw_frz_pc_write3", 32'(pc_write), 0);
    tick();
    mem_ack = 1'b1;
    #1;
    check("sw_ack_pc_write", 32'(pc_write), 1);
    tick();
    check("sw_adv_mem", 32'(ctrl_mem), 32'(C_R));
    check("sw_stall", 32'(stall_count), 5);
    check("sw_state_run", 32'(dbg_state), st_run);
    check("sw_no_err", 32'(mem_err), 0);

    // load never acknowledged: timeout after 4 wait cycles
    mem_ack = 1'b0;
    drive(C_LW, 5'd1, 5'd3); tick();
    drive(C_NOP, 5'd0, 5'd0); tick();
    check("to_frz", 32'(pc_write), 0);
    repeat (4) tick();
    check("to_hit_pc_write", 32'(pc_write), 1);
    check("to_err_pending", 32'(mem_err), 0);
    tick();
    check("to_err", 32'(mem_err), 1);
    check("to_wb", 32'(ctrl_wb), 3);
    check("to_stall", 32'(stall_count), 9);
    check("to_state", 32'(dbg_state), st_run);

    // reset in the middle of a wait
    drive(C_LW, 5'd1, 5'd3); tick();
    drive(C_NOP, 5'd0, 5'd0); tick();
    tick(); tick();
    check("midrst_wait", 32'(dbg_state), st_wait);
    reset = 1'b1;
    tick();
    check("midrst_state", 32'(dbg_state), st_run);
    check("midrst_err", 32'(mem_err), 0);
    check("midrst_ex", 32'(ctrl_ex), 0);
    check("midrst_mem", 32'(ctrl_mem), 0);
    check("midrst_wb", 32'(ctrl_wb), 0);
    check("midrst_stall", 32'(stall_count), 0);
    reset = 1'b0;

    // saturation: 5 timed-out loads x 4 stalls each, capped at 15
    for (int k = 0; k < 5; k++) begin
      drive(C_LW, 5'd0, 5'd3); tick();
      drive(C_NOP, 5'd0, 5'd0); tick();
      repeat (5) tick();
      if (k == 2) check("sat_mid", 32'(stall_count), 12);
    end
    check("sat_final", 32'(stall_count), 15);
    check("sat_err", 32'(mem_err), 1);
    mem_ack = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage MIPS pipeline.
- Owns the ID/EX, EX/MEM and MEM/WB control-bundle registers fed by the ID-stage opcode decoder.
- Detects load-use hazards, flushes on taken branches and jumps, and freezes the pipe during data-memory request/acknowledge waits.
- Generates PC and IF/ID write/flush enables and keeps a saturating stall-cycle counter.

Parameters:
- MEM_TIMEOUT, 64: max cycles to wait for mem_ack before aborting the access and flagging an error.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ctrl_id  in  10  ID-stage bundle {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,ALUOp[1:0]}
- rs_id  in  5  ID-stage rs field
- rt_id  in  5  ID-stage rt field
- alu_zero_ex  in  1  EX-stage ALU zero flag
- mem_ack  in  1  data memory completes the current access this cycle
- ctrl_ex  out  10  ID/EX control register
- ctrl_mem  out  10  EX/MEM control register
- ctrl_wb  out  2  MEM/WB {RegWrite,MemtoReg}
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID is loaded with a NOP
- pc_sel  out  2  00 PC+4, 01 branch target, 10 jump target
- mem_req  out  1  data memory request
- mem_err  out  1  sticky timeout flag
- stall_count  out  CNT_W  saturating count of frozen/stalled cycles

Behaviour:
- Reset values: all ctrl registers 0; rt_ex 0; state RUN; mem_err 0; stall_count 0. Reset has priority over every event, including mid-wait.
- Combinational outputs: pc_write, ifid_write, ifid_flush, pc_sel, mem_req. During reset they evaluate from the zeroed registers: pc_write=1, ifid_write=1, ifid_flush=0, pc_sel=00, mem_req=0.
- mem_req = ctrl_mem.MemRead | ctrl_mem.MemWrite, in both RUN and MEM_WAIT.
- Only the defined bits RegWrite, ALUSrc, MemRead, MemWrite, Branch and Jump of ctrl_id are consumed for decisions. RegDst and MemtoReg may be don't-care and are copied through unchanged.
- use_rt = MemWrite | Branch | (RegWrite & ~ALUSrc), taken from ctrl_id.
- load_use = ctrl_ex.MemRead & rt_ex≠0 & (rt_ex==rs_id | (use_rt & rt_ex==rt_id)). rt_ex is an internal copy of rt_id captured with ctrl_ex.
- br_taken = ctrl_ex.Branch & alu_zero_ex.
- Stall/flush priority, highest first:
  - freeze (mem_req & ~mem_ack & state≠timeout): pc_write=0, ifid_write=0; ctrl_ex and ctrl_mem hold; ctrl_wb<=0.
  - br_taken: pc_sel=01, ifid_flush=1, ctrl_ex<=0, pc_write=1. A simultaneous load_use or Jump in ID is discarded.
  - load_use: pc_write=0, ifid_write=0, ctrl_ex<=0 (bubble); ctrl_mem and ctrl_wb advance. Exactly one bubble per hazard.
  - ctrl_id.Jump: pc_sel=10, ifid_flush=1, ctrl_ex<=ctrl_id.
  - otherwise: normal advance.
- FSM:
  - RUN -> MEM_WAIT when mem_req & ~mem_ack. Wait counter loaded to 1.
  - MEM_WAIT: counter increments each cycle. On mem_ack -> RUN and the pipe advances that same cycle.
  - MEM_WAIT, counter==MEM_TIMEOUT without ack: set mem_err, treat the cycle as ack (advance, ctrl_wb takes the access normally), -> RUN.
  - Ack in the request's first cycle means zero stall cycles.
- Stall counter: +1 on every cycle with pc_write=0. Saturates at all-ones. Branch and jump flushes are not counted.

Decomposition:
- Package pipeline_pkg:
  - bundle bit-index localparams (CTL_REGDST..CTL_ALUOP) and the width of 10
  - opcode constants R_FORMAT=0, J=2, BEQ=4, LW=35, SW=43
  - FSM state encoding RUN, MEM_WAIT
- Sub-module hazard_detect (combinational): computes use_rt and load_use from ctrl_id, rs_id, rt_id, ctrl_ex.MemRead and rt_ex.

Test Plan:
- After reset, feed LW (rt=8) then R-format rs=8 -> one cycle with pc_write=0, ifid_write=0, ctrl_ex=0; stall_count=1; the R-format reaches ctrl_ex the following cycle.
- LW rt=0 then R-format rs=0 -> no stall. LW rt=9 then LW rs=3 rt=9 -> no stall (rt unused).
- BEQ in EX with alu_zero_ex=1 while ID holds a load-use dependent -> pc_sel=01, ifid_flush=1, ctrl_ex=0, pc_write=1, stall_count unchanged.
- J in ID -> pc_sel=10, ifid_flush=1 for exactly one cycle; ctrl_ex.Jump=1 next cycle.
- SW reaches MEM, mem_ack held low 3 cycles -> pc_write=0 for 3 cycles, ctrl_wb=0, ctrl_mem stable; advance on the ack cycle; stall_count=3.
- mem_ack never asserted with MEM_TIMEOUT=4 -> mem_err=1 after 4 wait cycles, pipe advances; assert reset mid-wait -> state RUN, mem_err=0, all ctrl 0.
